// File: rtl/nextasic_pkg.sv
// rtl/nextasic_pkg.sv - shared constants and FSM state type for the sender arbiter
package nextasic_pkg;

   localparam int FRAME_W = 40;

   localparam int KBD   = 0;
   localparam int MOUSE = 1;
   localparam int SND   = 2;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STROBE = 2'd1,
      GAP    = 2'd2
   } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin pick over a request vector with an owned rotating pointer
module rr_arbiter #(
   parameter  int NREQ = 3,
   localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [NREQ-1:0] req,
   input  logic            advance,
   output logic [IDW-1:0]  grant,
   output logic            grant_valid
);

   logic [IDW-1:0] ptr;
   int             idx;

   // Walk from the farthest candidate down to ptr so the closest requester wins.
   always_comb begin
      grant       = '0;
      grant_valid = 1'b0;
      idx         = 0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         idx = (int'(ptr) + k) % NREQ;
         if (req[idx]) begin
            grant       = IDW'(idx);
            grant_valid = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= '0;
      end else if (advance && grant_valid) begin
         ptr <= (int'(grant) == NREQ - 1) ? '0 : grant + IDW'(1);
      end
   end

endmodule

// File: rtl/sender_arbiter.sv
// rtl/sender_arbiter.sv - shares one serial sender between several frame requesters
module sender_arbiter
   import nextasic_pkg::*;
#(
   parameter  int NREQ         = 3,
   parameter  int FRAME_W      = nextasic_pkg::FRAME_W,
   parameter  int VALID_CYCLES = 2,
   parameter  int GAP_CYCLES   = 4,
   localparam int IDW          = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NREQ-1:0]         req,
   input  logic [NREQ*FRAME_W-1:0] req_data,
   output logic [NREQ-1:0]         ack,
   output logic [FRAME_W-1:0]      tx_data,
   output logic                    tx_valid,
   output logic [IDW-1:0]          grant_id,
   output logic                    busy
);

   localparam int CMAX = (VALID_CYCLES > GAP_CYCLES) ? VALID_CYCLES : GAP_CYCLES;
   localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

   state_t         state, state_nx;
   logic [CW-1:0]  cnt, cnt_nx;
   logic [IDW-1:0] arb_grant;
   logic           arb_valid;
   logic           advance;

   rr_arbiter #(.NREQ(NREQ)) u_rr (
      .clk         (clk),
      .rst_n       (rst_n),
      .req         (req),
      .advance     (advance),
      .grant       (arb_grant),
      .grant_valid (arb_valid)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      advance  = 1'b0;
      case (state)
         IDLE: begin
            if (arb_valid) begin
               state_nx = STROBE;
               cnt_nx   = '0;
               advance  = 1'b1;
            end
         end
         STROBE: begin
            if (cnt == CW'(VALID_CYCLES - 1)) begin
               cnt_nx   = '0;
               state_nx = (GAP_CYCLES == 0) ? IDLE : GAP;
            end else begin
               cnt_nx = cnt + CW'(1);
            end
         end
         GAP: begin
            if (cnt == CW'(GAP_CYCLES - 1)) begin
               cnt_nx   = '0;
               state_nx = IDLE;
            end else begin
               cnt_nx = cnt + CW'(1);
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // Frame and id stay put until the next grant, so the sender can resample freely.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_data  <= '0;
         grant_id <= '0;
         ack      <= '0;
      end else begin
         ack <= '0;
         if (advance) begin
            tx_data  <= req_data[int'(arb_grant)*FRAME_W +: FRAME_W];
            grant_id <= arb_grant;
            ack      <= NREQ'(1) << arb_grant;
         end
      end
   end

   assign tx_valid = (state == STROBE);
   assign busy     = (state != IDLE);

endmodule

// File: tb/tb_sender_arbiter.sv
// tb/tb_sender_arbiter.sv - randomized self-checking bench for sender_arbiter
module tb_sender_arbiter;

   localparam int NR = 3;
   localparam int FW = 40;
   localparam int VC = 2;
   localparam int GC = 4;
   localparam int IDLE_SINCE = 1000;

   logic           clk;
   logic           rst_n;
   logic [NR-1:0]  req;
   logic [NR*FW-1:0] req_data;
   logic [NR-1:0]  ack;
   logic [FW-1:0]  tx_data;
   logic           tx_valid;
   logic [1:0]     grant_id;
   logic           busy;

   logic [FW-1:0]  frames [NR];
   assign req_data = {frames[2], frames[1], frames[0]};

   sender_arbiter #(.NREQ(NR), .FRAME_W(FW), .VALID_CYCLES(VC), .GAP_CYCLES(GC)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (req),
      .req_data (req_data),
      .ack      (ack),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .grant_id (grant_id),
      .busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: cycles since the last grant decide every output.
   int            m_since;
   int            m_p;
   int            m_gid;
   logic [FW-1:0] m_data;
   logic          prev_valid;
   logic [FW-1:0] prev_data;

   function automatic logic [NR-1:0] model_ack();
      return (m_since == 0) ? (NR'(1) << m_gid) : '0;
   endfunction

   task automatic model_reset();
      m_since    = IDLE_SINCE;
      m_p        = 0;
      m_gid      = 0;
      m_data     = '0;
      prev_valid = 1'b0;
   endtask

   task automatic model_edge();
      if (m_since >= VC + GC && req != '0) begin
         for (int k = 0; k < NR; k++) begin
            int i;
            i = (m_p + k) % NR;
            if (req[i]) begin
               m_gid   = i;
               m_data  = frames[i];
               m_p     = (i + 1) % NR;
               m_since = 0;
               break;
            end
         end
      end else if (m_since < IDLE_SINCE) begin
         m_since++;
      end
   endtask

   task automatic check_outputs();
      check("ack", 64'(ack), 64'(model_ack()));
      check("tx_valid", 64'(tx_valid), 64'(m_since < VC));
      check("busy", 64'(busy), 64'(m_since < VC + GC));
      check("tx_data", 64'(tx_data), 64'(m_data));
      check("grant_id", 64'(grant_id), 64'(m_gid));
      check("ack_onehot0", 64'($onehot0(ack)), 64'(1));
      check("valid_implies_busy", 64'(tx_valid && !busy), 64'(0));
      if (prev_valid && tx_valid) check("tx_data_stable", 64'(tx_data), 64'(prev_data));
      prev_valid = tx_valid;
      prev_data  = tx_data;
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check_outputs();
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      req   = '0;
      #1;
      model_reset();
      check_outputs();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic reset_mid_strobe(input logic [NR-1:0] after_req, input int exp_gid);
      do_reset();
      frames[0] = 40'h0000000A5A;
      frames[1] = 40'h0000000B5B;
      frames[2] = 40'h0000000C5C;
      req = 3'b001;
      step();
      req = '0;
      rst_n = 1'b0;
      #1;
      model_reset();
      check("rst_mid_tx_valid", 64'(tx_valid), 64'(0));
      check("rst_mid_busy", 64'(busy), 64'(0));
      check_outputs();
      @(negedge clk);
      req   = after_req;
      rst_n = 1'b1;
      step();
      check("rst_regrant_id", 64'(grant_id), 64'(exp_gid));
      req = '0;
      repeat (VC + GC + 1) step();
   endtask

   initial begin
      int          grants;
      int          order [4];
      int          cyc;
      int          last_rise;
      logic        was_valid;
      logic [63:0] rnd;
      logic [NR-1:0] cur_ack;

      rst_n = 1'b0;
      req   = '0;
      for (int i = 0; i < NR; i++) frames[i] = '0;
      model_reset();
      #2;
      check_outputs();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      frames[0] = 40'hD999999991;
      req = 3'b001;
      step();
      check("single_ack", 64'(ack), 64'(3'b001));
      check("single_data", 64'(tx_data), 64'(40'hD999999991));
      req = '0;
      repeat (VC + GC) step();
      check("single_busy_done", 64'(busy), 64'(0));
      step();

      do_reset();
      frames[0] = 40'h1;
      frames[1] = 40'h2;
      frames[2] = 40'h3;
      req = 3'b111;
      order = '{0, 1, 2, 0};
      grants = 0;
      last_rise = -1;
      was_valid = 1'b0;
      for (cyc = 0; cyc < 40 && grants < 4; cyc++) begin
         step();
         if (ack != '0) begin
            check("rr_order", 64'(grant_id), 64'(order[grants]));
            grants++;
         end
         if (tx_valid && !was_valid) begin
            if (last_rise >= 0) check("rise_spacing", 64'(cyc - last_rise), 64'(VC + GC + 1));
            last_rise = cyc;
         end
         was_valid = tx_valid;
      end
      check("rr_grant_count", 64'(grants), 64'(4));
      req = '0;
      repeat (VC + GC + 1) step();

      reset_mid_strobe(3'b010, 1);
      reset_mid_strobe(3'b101, 0);

      do_reset();
      for (int n = 0; n < 3000; n++) begin
         step();
         cur_ack = model_ack();
         for (int i = 0; i < NR; i++) begin
            if (req[i]) begin
               if (cur_ack[i] && $urandom_range(1, 0) == 0) req[i] = 1'b0;
            end else if ($urandom_range(4, 0) == 0) begin
               rnd = {$urandom, $urandom};
               frames[i] = rnd[FW-1:0];
               req[i] = 1'b1;
            end
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sender_arbiter.md
SENDER_ARBITER -- requirements
Module: sender_arbiter

Interface
REQ-001 Parameter NREQ, default 3: number of frame requesters (keyboard, mouse, sound status).
REQ-002 Parameter FRAME_W, default 40: frame width in bits, matching the serial sender data input.
REQ-003 Parameter VALID_CYCLES, default 2: clk cycles tx_valid is held per frame.
REQ-004 Parameter GAP_CYCLES, default 4: idle clk cycles after tx_valid drops, covering sender serialization time.
REQ-005 clk  input  1  sole clock, same domain as the sender's input side.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 req  input  NREQ  per-requester level request; bit i is held until ack[i].
REQ-008 req_data  input  NREQ*FRAME_W  frame of requester i at bits [i*FRAME_W +: FRAME_W]; stable while req[i] is high.
REQ-009 ack  output  NREQ  one-cycle pulse on the cycle requester i's frame is latched.
REQ-010 tx_data  output  FRAME_W  frame driven to the sender.
REQ-011 tx_valid  output  1  frame strobe to the sender.
REQ-012 grant_id  output  clog2(NREQ)  index of the last granted requester.
REQ-013 busy  output  1  high in every state except IDLE.

Function
REQ-014 The FSM SHALL have exactly these states: IDLE, STROBE, GAP.
REQ-015 IDLE: if any req bit is sampled high at a clk edge, the FSM SHALL pick the winner by round-robin and enter STROBE on that edge; otherwise it stays in IDLE.
REQ-016 Round-robin: search starts at pointer p (reset 0) and proceeds p, p+1, ... mod NREQ; after granting i, p SHALL become (i+1) mod NREQ.
REQ-017 On the granting edge: tx_data SHALL load the winner's frame, grant_id SHALL load i, ack[i] SHALL go high for exactly one cycle, and tx_valid SHALL go high.
REQ-018 Latency: req[i] sampled high at edge k in IDLE -> ack[i] and tx_valid high in the cycle after edge k.
REQ-019 STROBE SHALL last exactly VALID_CYCLES cycles with tx_valid high, then enter GAP with tx_valid low.
REQ-020 GAP SHALL last exactly GAP_CYCLES cycles, then enter IDLE; with GAP_CYCLES=0, STROBE SHALL go directly to IDLE.
REQ-021 Minimum spacing between tx_valid rising edges SHALL be VALID_CYCLES+GAP_CYCLES+1 cycles.
REQ-022 tx_data SHALL hold its value from one load to the next, including during GAP and IDLE.
REQ-023 Changes on req or req_data outside IDLE SHALL be ignored; requests are not queued beyond the live req level.
REQ-024 A requester that keeps req high after ack SHALL be treated as a new request at the next IDLE.
REQ-025 At most one ack bit SHALL be high in any cycle.

Reset
REQ-026 While rst_n is low: state=IDLE, p=0, ack=0, tx_valid=0, tx_data=0, grant_id=0, busy=0, applied asynchronously.
REQ-027 A reset asserted mid-STROBE SHALL drop tx_valid immediately, with no ack re-issued after release.
REQ-028 The first arbitration SHALL occur on the first clk edge that samples rst_n high.

Structure
REQ-029 The shared package nextasic_pkg SHALL hold FRAME_W, the state enum, and the requester index constants (KBD=0, MOUSE=1, SND=2).
REQ-030 The round-robin pick and pointer update SHALL be one sub-module, rr_arbiter (inputs req, advance; outputs grant index, grant_valid).
REQ-031 The block SHALL contain no clock-domain crossing; the CDC is handled by the sender.

Verification
REQ-032 Single request: req=3'b001, frame0=40'hD999999991 -> ack=3'b001 for 1 cycle; tx_valid high 2 cycles; tx_data=40'hD999999991; busy low 7 cycles after the grant edge.
REQ-033 All three requesters asserted from reset with frames 40'h1, 40'h2, 40'h3 and held -> grants in order 0,1,2,0; tx_valid rises every 7 cycles.
REQ-034 Fairness: req=3'b011 held continuously -> grant_id alternates 0,1,0,1; neither requester is granted twice in a row.
REQ-035 Late request: req[2] rises during GAP with frame 40'h9999999993 -> no ack until IDLE; then granted, and tx_data updates only at that edge.
REQ-036 Reset during STROBE cycle 1 -> tx_valid=0 and busy=0 immediately; after release with req=3'b010, grant goes to 1 with p restarted at 0.
REQ-037 Assertions in every test: ack is one-hot or zero; tx_data is stable whenever tx_valid is high; tx_valid is never high in IDLE.
